// File: rtl/rx_frame_drain_ctrl.sv
// Read-side drain controller for the RX frame ring: parses frame headers, streams
// frame data on an AXI-Stream master and hands freed ring space back to the writer.
module rx_frame_drain_ctrl #(
   parameter int AW          = 15,
   parameter int HOLD_CYCLES = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic [AW-1:0] commited_wr_address,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   input  logic [63:0]   rd_data,
   output logic [63:0]   m_axis_tdata,
   output logic [7:0]    m_axis_tkeep,
   output logic [15:0]   m_axis_tuser,
   output logic          m_axis_tvalid,
   output logic          m_axis_tlast,
   input  logic          m_axis_tready,
   output logic [AW-1:0] commited_rd_address,
   output logic          rd_addr_updated,
   output logic [31:0]   frames_sent,
   output logic [31:0]   zero_len_frames
);

   localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR_RD,
      S_HDR,
      S_STREAM,
      S_COMMIT,
      S_HOLD
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   rd_ptr, data_ptr, next_ptr;
   logic [13:0]     words_left;
   logic [7:0]      last_keep;
   logic [HCW-1:0]  hold_cnt;

   // Read pipeline: data_rd_q marks a data read on the bus this cycle,
   // d_valid marks its word present on rd_data the following cycle.
   logic            data_rd_q, rd_last_q;
   logic            d_valid, d_last;

   // Two-entry FIFO sitting behind the registered AXI-S output beat.
   logic [63:0]     q_data [2];
   logic [7:0]      q_keep [2];
   logic            q_last [2];
   logic            q_head;
   logic [1:0]      q_cnt;

   logic            start_hdr, issue_rd, issue_last, frame_done;
   logic            can_start, pop, load_out, fifo_pop, push_q, room, q_tail;
   logic [2:0]      pending;
   logic [AW-1:0]   ptr_inc, issue_addr;
   logic [15:0]     hdr_len;
   logic [2:0]      hdr_rem;
   logic [13:0]     hdr_words;
   logic [7:0]      hdr_keep, d_keep;
   logic            unused_hdr_bits;

   assign hdr_len         = rd_data[47:32];
   assign hdr_rem         = hdr_len[2:0];
   assign hdr_words       = 14'(({1'b0, hdr_len} + 17'd7) >> 3);
   assign hdr_keep        = (hdr_rem == 3'd0) ? 8'hFF : (8'hFF >> (4'd8 - {1'b0, hdr_rem}));
   assign unused_hdr_bits = ^rd_data[31:0];

   assign ptr_inc    = rd_ptr + AW'(1);
   assign issue_addr = (state_q == S_HDR) ? ptr_inc : data_ptr;
   assign can_start  = enable && (rd_ptr != commited_wr_address);

   assign pop      = m_axis_tvalid && m_axis_tready;
   assign load_out = !m_axis_tvalid || pop;
   assign fifo_pop = load_out && (q_cnt != 2'd0);
   assign push_q   = d_valid && !(load_out && (q_cnt == 2'd0));
   assign q_tail   = q_head ^ q_cnt[0];
   assign d_keep   = d_last ? last_keep : 8'hFF;

   // Every word already owned (output beat, FIFO, arriving, on the bus) must fit
   // in three slots; this cycle's pop frees one, which keeps beats back-to-back.
   assign pending = 3'(m_axis_tvalid) + 3'(q_cnt) + 3'(d_valid) + 3'(data_rd_q);
   assign room    = (pending - 3'(pop)) < 3'd3;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      start_hdr  = 1'b0;
      issue_rd   = 1'b0;
      issue_last = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (can_start) begin
               start_hdr = 1'b1;
               state_d   = S_HDR_RD;
            end
         end
         S_HDR_RD: state_d = S_HDR;
         S_HDR: begin
            if (hdr_len == 16'd0) begin
               state_d = S_COMMIT;
            end else begin
               issue_rd   = 1'b1;
               issue_last = (hdr_words == 14'd1);
               state_d    = S_STREAM;
            end
         end
         S_STREAM: begin
            if ((words_left != 14'd0) && room) begin
               issue_rd   = 1'b1;
               issue_last = (words_left == 14'd1);
            end
            if (pop && m_axis_tlast) begin
               frame_done = 1'b1;
               state_d    = S_COMMIT;
            end
         end
         S_COMMIT: state_d = S_HOLD;
         S_HOLD: begin
            // The last hold cycle doubles as IDLE so the next header read follows at once.
            if (hold_cnt == '0) begin
               if (can_start) begin
                  start_hdr = 1'b1;
                  state_d   = S_HDR_RD;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_en               <= 1'b0;
         rd_addr             <= '0;
         data_rd_q           <= 1'b0;
         rd_last_q           <= 1'b0;
         rd_ptr              <= '0;
         data_ptr            <= '0;
         next_ptr            <= '0;
         words_left          <= '0;
         last_keep           <= 8'hFF;
         m_axis_tuser        <= '0;
         commited_rd_address <= '0;
         rd_addr_updated     <= 1'b0;
         hold_cnt            <= '0;
         frames_sent         <= '0;
         zero_len_frames     <= '0;
      end else begin
         rd_en     <= start_hdr || issue_rd;
         data_rd_q <= issue_rd;
         rd_last_q <= issue_last;
         if (start_hdr) begin
            rd_addr <= rd_ptr;
         end else if (issue_rd) begin
            rd_addr <= issue_addr;
         end

         if (state_q == S_HDR) begin
            m_axis_tuser <= rd_data[63:48];
            last_keep    <= hdr_keep;
            if (hdr_len == 16'd0) begin
               zero_len_frames <= zero_len_frames + 32'd1;
               next_ptr        <= ptr_inc;
            end else begin
               data_ptr   <= ptr_inc + AW'(1);
               words_left <= hdr_words - 14'd1;
            end
         end else if (issue_rd) begin
            data_ptr   <= data_ptr + AW'(1);
            words_left <= words_left - 14'd1;
         end

         if (frame_done) begin
            frames_sent <= frames_sent + 32'd1;
            next_ptr    <= data_ptr;
         end

         if (state_q == S_COMMIT) begin
            commited_rd_address <= next_ptr;
            rd_ptr              <= next_ptr;
            rd_addr_updated     <= 1'b1;
            hold_cnt            <= HCW'(HOLD_CYCLES - 1);
         end else if (state_q == S_HOLD) begin
            if (hold_cnt == '0) begin
               rd_addr_updated <= 1'b0;
            end else begin
               hold_cnt <= hold_cnt - HCW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         d_valid       <= 1'b0;
         d_last        <= 1'b0;
         q_head        <= 1'b0;
         q_cnt         <= '0;
      end else begin
         d_valid <= data_rd_q;
         d_last  <= rd_last_q;
         if (load_out) begin
            if (q_cnt != 2'd0) begin
               m_axis_tdata  <= q_data[q_head];
               m_axis_tkeep  <= q_keep[q_head];
               m_axis_tlast  <= q_last[q_head];
               m_axis_tvalid <= 1'b1;
            end else if (d_valid) begin
               m_axis_tdata  <= rd_data;
               m_axis_tkeep  <= d_keep;
               m_axis_tlast  <= d_last;
               m_axis_tvalid <= 1'b1;
            end else begin
               m_axis_tvalid <= 1'b0;
               m_axis_tlast  <= 1'b0;
            end
         end
         q_head <= q_head ^ fifo_pop;
         q_cnt  <= q_cnt + 2'(push_q) - 2'(fifo_pop);
      end
   end

   // NOTE: FIFO storage has no reset; q_cnt qualifies every entry, so its contents never leak.
   always_ff @(posedge clk) begin
      if (push_q) begin
         q_data[q_tail] <= rd_data;
         q_keep[q_tail] <= d_keep;
         q_last[q_tail] <= d_last;
      end
   end

endmodule

// File: tb/tb_rx_frame_drain_ctrl.sv
// Directed bench for rx_frame_drain_ctrl on a 16-word ring: table of frames plus
// hand sequences for back-to-back commits, mid-frame reset and enable gating.
module tb_rx_frame_drain_ctrl;
   localparam int AW   = 4;
   localparam int HOLD = 4;

   logic          clk, reset, enable;
   logic [AW-1:0] commited_wr_address;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [63:0]   rd_data;
   logic [63:0]   m_axis_tdata;
   logic [7:0]    m_axis_tkeep;
   logic [15:0]   m_axis_tuser;
   logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
   logic [AW-1:0] commited_rd_address;
   logic          rd_addr_updated;
   logic [31:0]   frames_sent, zero_len_frames;

   rx_frame_drain_ctrl #(.AW(AW), .HOLD_CYCLES(HOLD)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .commited_wr_address(commited_wr_address),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
      .commited_rd_address(commited_rd_address),
      .rd_addr_updated(rd_addr_updated),
      .frames_sent(frames_sent), .zero_len_frames(zero_len_frames)
   );

   typedef struct {
      logic [AW-1:0] hdr;
      logic [15:0]   len;
      logic [7:0]    des;
      logic [7:0]    src;
      bit            stall;
      int            exp_beats;
      logic [7:0]    exp_keep;
      logic [AW-1:0] exp_commit;
   } vec_t;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic [15:0] user;
   } beat_t;

   vec_t          vecs [7];
   beat_t         beats [$];
   logic [AW-1:0] pulse_vals [$];
   logic [63:0]   mem [16];
   int            total, bad;
   int            pulses_done, pulse_len, last_pulse_len;
   int            exp_frames, exp_zero;
   bit            stall_mode;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Ring buffer read port: one-cycle read latency.
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_axis_tready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pat(int f, int i);
      return {32'hDA7A0000 | 32'(f), 32'h0000B000 | 32'(i)};
   endfunction

   // Monitor: accepted beats, stability under stall, commit pulses.
   initial begin
      bit            prev_stall, prev_upd;
      beat_t         prev_b;
      logic [AW-1:0] pulse_val;
      prev_stall = 0;
      prev_upd   = 0;
      pulse_val  = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_stall = 0;
            prev_upd   = 0;
         end else begin
            if (prev_stall) begin
               check("stall_tdata", m_axis_tdata, prev_b.data);
               check("stall_ctrl", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tuser},
                     {1'b1, prev_b.last, prev_b.keep, prev_b.user});
            end
            if (m_axis_tvalid && m_axis_tready)
               beats.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser});
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_b     = '{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
            if (rd_addr_updated && !prev_upd) begin
               pulse_len = 1;
               pulse_val = commited_rd_address;
            end else if (rd_addr_updated) begin
               pulse_len++;
               check("commit_stable", 64'(commited_rd_address), 64'(pulse_val));
            end else if (prev_upd) begin
               pulses_done++;
               pulse_vals.push_back(pulse_val);
               last_pulse_len = pulse_len;
            end
            prev_upd = rd_addr_updated;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_reset_outputs(string tag);
      check({tag, "_rd_en"}, 64'(rd_en), 64'd0);
      check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
      check({tag, "_tvalid_tlast"}, {62'd0, m_axis_tvalid, m_axis_tlast}, 64'd0);
      check({tag, "_tdata"}, m_axis_tdata, 64'd0);
      check({tag, "_tkeep_tuser"}, {40'd0, m_axis_tkeep, m_axis_tuser}, 64'd0);
      check({tag, "_commit"}, {59'd0, commited_rd_address, rd_addr_updated}, 64'd0);
      check({tag, "_counters"}, {frames_sent, zero_len_frames}, 64'd0);
   endtask

   task automatic write_frame(int k);
      vec_t v = vecs[k];
      mem[v.hdr] = {v.des, v.src, v.len, 32'h0};
      for (int i = 0; i < v.exp_beats; i++) mem[v.hdr + AW'(1 + i)] = pat(k, i);
   endtask

   task automatic run_frame(int k);
      vec_t v = vecs[k];
      int   start, first, lastc, n;
      stall_mode = v.stall;
      write_frame(k);
      beats.delete();
      start = pulses_done;
      first = -1;
      lastc = -1;
      @(posedge clk);
      #1;
      enable              = 1'b1;
      commited_wr_address = v.exp_commit;
      for (int c = 0; c < 400 && pulses_done == start; c++) begin
         @(negedge clk);
         #1;
         if (m_axis_tvalid && first < 0) first = c;
         if (m_axis_tvalid && m_axis_tready) lastc = c;
      end
      check($sformatf("f%0d_commit_seen", k), 64'(pulses_done), 64'(start + 1));
      if (v.len == 16'd0) exp_zero++;
      else exp_frames++;
      n = beats.size();
      check($sformatf("f%0d_beats", k), 64'(n), 64'(v.exp_beats));
      for (int i = 0; i < n; i++) begin
         check($sformatf("f%0d_b%0d_data", k, i), beats[i].data, pat(k, i));
         check($sformatf("f%0d_b%0d_keep", k, i), 64'(beats[i].keep),
               64'((i == v.exp_beats - 1) ? v.exp_keep : 8'hFF));
         check($sformatf("f%0d_b%0d_last", k, i), 64'(beats[i].last), 64'(i == v.exp_beats - 1));
         check($sformatf("f%0d_b%0d_user", k, i), 64'(beats[i].user), 64'({v.des, v.src}));
      end
      if (v.exp_beats > 0) begin
         check($sformatf("f%0d_first_valid_cycle", k), 64'(first), 64'd5);
         if (!v.stall)
            check($sformatf("f%0d_back_to_back", k), 64'(lastc - first + 1), 64'(v.exp_beats));
      end
      if (pulse_vals.size() > 0)
         check($sformatf("f%0d_pulse_val", k), 64'(pulse_vals[$]), 64'(v.exp_commit));
      check($sformatf("f%0d_pulse_len", k), 64'(last_pulse_len), 64'(HOLD));
      check($sformatf("f%0d_commited_rd", k), 64'(commited_rd_address), 64'(v.exp_commit));
      check($sformatf("f%0d_frames_sent", k), 64'(frames_sent), 64'(exp_frames));
      check($sformatf("f%0d_zero_len", k), 64'(zero_len_frames), 64'(exp_zero));
   endtask

   initial begin
      int  start, n, rd_cnt, tv_cnt;
      bit  prev_u, seen;
      total = 0; bad = 0; pulses_done = 0; pulse_len = 0; last_pulse_len = 0;
      exp_frames = 0; exp_zero = 0; stall_mode = 0;
      reset = 1'b1; enable = 1'b1; commited_wr_address = '0;
      for (int i = 0; i < 16; i++) mem[i] = 64'h0;

      //          hdr    len      des    src    stall beats keep   commit
      vecs[0] = '{4'd0,  16'd20, 8'h12, 8'h34, 1'b0, 3, 8'h0F, 4'd4};
      vecs[1] = '{4'd4,  16'd64, 8'h56, 8'h78, 1'b1, 8, 8'hFF, 4'd13};
      vecs[2] = '{4'd13, 16'd0,  8'h9A, 8'hBC, 1'b0, 0, 8'hFF, 4'd14};
      vecs[3] = '{4'd14, 16'd24, 8'hDE, 8'hF0, 1'b1, 3, 8'hFF, 4'd2};
      vecs[4] = '{4'd2,  16'd7,  8'h01, 8'h02, 1'b0, 1, 8'h7F, 4'd4};
      vecs[5] = '{4'd4,  16'd9,  8'h03, 8'h04, 1'b1, 2, 8'h01, 4'd7};
      vecs[6] = '{4'd0,  16'd33, 8'h05, 8'h06, 1'b0, 5, 8'h01, 4'd6};

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      reset = 1'b0;

      for (int k = 0; k < 6; k++) run_frame(k);

      // Two frames committed at once: 7 (len 16) and 10 (len 12).
      stall_mode = 0;
      mem[7]  = {8'hA1, 8'hB1, 16'd16, 32'h0};
      mem[8]  = pat(7, 0);
      mem[9]  = pat(7, 1);
      mem[10] = {8'hA2, 8'hB2, 16'd12, 32'h0};
      mem[11] = pat(8, 0);
      mem[12] = pat(8, 1);
      beats.delete();
      pulse_vals.delete();
      start  = pulses_done;
      prev_u = 0;
      seen   = 0;
      @(posedge clk);
      #1;
      commited_wr_address = 4'd13;
      for (int c = 0; c < 400 && pulses_done < start + 2; c++) begin
         @(negedge clk);
         #1;
         if (prev_u && !rd_addr_updated && !seen) begin
            seen = 1;
            check("b2b_hdr_rd_en", 64'(rd_en), 64'd1);
            check("b2b_hdr_rd_addr", 64'(rd_addr), 64'd10);
         end
         prev_u = rd_addr_updated;
      end
      exp_frames += 2;
      check("b2b_pulses", 64'(pulses_done), 64'(start + 2));
      n = beats.size();
      check("b2b_beats", 64'(n), 64'd4);
      if (n == 4) begin
         check("b2b_data", {beats[0].data ^ pat(7, 0), beats[1].data ^ pat(7, 1)}, 64'd0);
         check("b2b_data2", {beats[2].data ^ pat(8, 0), beats[3].data ^ pat(8, 1)}, 64'd0);
         check("b2b_last", {60'd0, beats[0].last, beats[1].last, beats[2].last, beats[3].last},
               64'b0101);
         check("b2b_keep", {32'd0, beats[0].keep, beats[1].keep, beats[2].keep, beats[3].keep},
               64'hFFFF_FF0F);
         check("b2b_user", {32'd0, beats[1].user, beats[2].user}, 64'hA1B1_A2B2);
      end
      if (pulse_vals.size() == 2)
         check("b2b_pulse_vals", {56'd0, pulse_vals[0], pulse_vals[1]}, 64'hAD);
      else
         check("b2b_pulse_count", 64'(pulse_vals.size()), 64'd2);
      check("b2b_frames_sent", 64'(frames_sent), 64'(exp_frames));

      // Reset in the middle of a 5-beat frame at 13.
      mem[13] = {8'hC1, 8'hC2, 16'd40, 32'h0};
      for (int i = 0; i < 5; i++) mem[4'd14 + 4'(i)] = pat(9, i);
      beats.delete();
      @(posedge clk);
      #1;
      commited_wr_address = 4'd3;
      for (int c = 0; c < 100 && beats.size() < 2; c++) begin
         @(negedge clk);
         #1;
      end
      check("mid_two_beats", 64'(beats.size()), 64'd2);
      #2;
      reset = 1'b1;
      commited_wr_address = '0;
      #1;
      check_reset_outputs("async");
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("held");
      reset = 1'b0;
      exp_frames = 0;
      exp_zero   = 0;

      // Enable low: a committed frame must not start.
      write_frame(6);
      enable = 1'b0;
      commited_wr_address = vecs[6].exp_commit;
      rd_cnt = 0;
      tv_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         #1;
         if (rd_en) rd_cnt++;
         if (m_axis_tvalid) tv_cnt++;
      end
      check("disabled_rd_en", 64'(rd_cnt), 64'd0);
      check("disabled_tvalid", 64'(tv_cnt), 64'd0);

      run_frame(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
